// File: rtl/bpi_flash_pkg.sv
// bpi_flash_pkg: shared states, error codes and status bit positions for the flash update sequencer
package bpi_flash_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CALC, S_ERASE, S_POLL, S_WR, S_WR_WAIT, S_WCHK, S_DONE, S_ERR
  } upd_state_e;
  typedef enum logic [2:0] {P_IDLE, P_GAP, P_REQ, P_WAIT, P_CHK} poll_state_e;
  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_RANGE = 3'd1;
  localparam logic [2:0] ERR_ERASE = 3'd2;
  localparam logic [2:0] ERR_LOCK  = 3'd3;
  localparam logic [2:0] ERR_TMO   = 3'd4;
  localparam logic [2:0] ERR_PROG  = 3'd5;
  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_LOCK      = 1;
endpackage

// File: rtl/bpi_flash_sts_poll.sv
// bpi_flash_sts_poll: gap / status-read / latency-wait / ready-check loop with poll timeout
module bpi_flash_sts_poll
  import bpi_flash_pkg::*;
#(
  parameter int          FLASH_DATA_WD = 16,
  parameter int          STS_LAT       = 4,
  parameter int          POLL_GAP      = 256,
  parameter logic [19:0] ERASE_TMO     = 20'd800000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     poll_start_i,
  input  logic                     skip_gap_i,
  input  logic [FLASH_DATA_WD-1:0] status_i,
  output logic                     rdsta_en_o,
  output logic                     poll_done_o,
  output logic                     poll_tmo_o,
  output logic [FLASH_DATA_WD-1:0] sts_q_o
);
  poll_state_e              st_q;
  logic [15:0]              tcnt_q;
  logic [19:0]              pcnt_q;
  logic [FLASH_DATA_WD-1:0] sts_q;
  logic                     ready;
  assign ready       = sts_q[SR_READY];
  assign rdsta_en_o  = st_q == P_REQ;
  assign poll_done_o = st_q == P_CHK && ready;
  assign poll_tmo_o  = st_q == P_CHK && !ready && pcnt_q + 20'd1 == ERASE_TMO;
  assign sts_q_o     = sts_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= P_IDLE;
      tcnt_q <= '0;
      pcnt_q <= '0;
      sts_q  <= '0;
    end else begin
      case (st_q)
        P_IDLE: if (poll_start_i) begin
          pcnt_q <= '0;
          tcnt_q <= '0;
          st_q   <= skip_gap_i ? P_REQ : P_GAP;
        end
        P_GAP: begin
          tcnt_q <= tcnt_q + 16'd1;
          if (tcnt_q == 16'(POLL_GAP - 1)) begin
            tcnt_q <= '0;
            st_q   <= P_REQ;
          end
        end
        P_REQ: st_q <= P_WAIT;
        P_WAIT: begin
          tcnt_q <= tcnt_q + 16'd1;
          if (tcnt_q == 16'(STS_LAT - 1)) begin
            tcnt_q <= '0;
            sts_q  <= status_i;
            st_q   <= P_CHK;
          end
        end
        P_CHK: if (ready || poll_tmo_o) st_q <= P_IDLE;
        else begin
          pcnt_q <= pcnt_q + 20'd1;
          st_q   <= P_GAP;
        end
        default: st_q <= P_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/bpi_flash_update_seq.sv
// bpi_flash_update_seq: erases every block of a host update range, then runs and checks the buffered write
module bpi_flash_update_seq
  import bpi_flash_pkg::*;
#(
  parameter int          FLASH_ADDR_WD = 26,
  parameter int          FLASH_DATA_WD = 16,
  parameter int          BLK_SHIFT     = 16,
  parameter int          STS_LAT       = 4,
  parameter int          POLL_GAP      = 256,
  parameter logic [19:0] ERASE_TMO     = 20'd800000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     upd_trig,
  input  logic [31:0]              upd_addr,
  input  logic [31:0]              upd_len,
  output logic                     upd_busy,
  output logic                     upd_done,
  output logic [2:0]               upd_err,
  output logic [15:0]              upd_blk_cnt,
  output logic                     unlock_erase_en,
  output logic [FLASH_ADDR_WD-1:0] block_num,
  output logic                     rdsta_en,
  input  logic [FLASH_DATA_WD-1:0] status,
  output logic                     cfg_wr_trig,
  output logic [31:0]              cfg_wr_addr,
  output logic [31:0]              cfg_wr_len,
  input  logic                     sts_wr_cpl
);
  localparam int BW = FLASH_ADDR_WD - BLK_SHIFT;
  upd_state_e               state_q;
  logic [31:0]              addr_q, len_q;
  logic [BW-1:0]            blk_cur_q, blk_last_q;
  logic [FLASH_ADDR_WD-1:0] block_num_q;
  logic [2:0]               err_q;
  logic [15:0]              blk_cnt_q;
  logic [1:0]               wcnt_q;
  logic [32:0]              end_w;
  logic                     wr_go, poll_start, poll_done, poll_tmo, unused_ok;
  logic [FLASH_DATA_WD-1:0] sts_q;
  assign end_w           = {1'b0, addr_q} + {1'b0, len_q} - 33'd1;
  assign wr_go           = state_q == S_WR_WAIT && wcnt_q == 2'd2 && sts_wr_cpl;
  assign poll_start      = state_q == S_ERASE || wr_go;
  assign upd_busy        = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign upd_done        = state_q inside {S_DONE, S_ERR};
  assign unlock_erase_en = state_q == S_ERASE;
  assign cfg_wr_trig     = state_q == S_WR;
  assign upd_err         = err_q;
  assign upd_blk_cnt     = blk_cnt_q;
  assign block_num       = block_num_q;
  assign cfg_wr_addr     = addr_q;
  assign cfg_wr_len      = len_q;
  assign unused_ok       = ^{end_w, sts_q};
  bpi_flash_sts_poll #(
    .FLASH_DATA_WD(FLASH_DATA_WD),
    .STS_LAT      (STS_LAT),
    .POLL_GAP     (POLL_GAP),
    .ERASE_TMO    (ERASE_TMO)
  ) u_poll (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .poll_start_i(poll_start),
    .skip_gap_i  (state_q == S_WR_WAIT),
    .status_i    (status),
    .rdsta_en_o  (rdsta_en),
    .poll_done_o (poll_done),
    .poll_tmo_o  (poll_tmo),
    .sts_q_o     (sts_q)
  );
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      blk_cur_q   <= '0;
      blk_last_q  <= '0;
      block_num_q <= '0;
      err_q       <= ERR_OK;
      blk_cnt_q   <= '0;
      wcnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (upd_trig) begin
          addr_q    <= upd_addr;
          len_q     <= upd_len;
          err_q     <= ERR_OK;
          blk_cnt_q <= '0;
          state_q   <= S_CALC;
        end
        S_CALC: if (len_q == '0) state_q <= S_DONE;
        else if (end_w[32] || |end_w[31:FLASH_ADDR_WD]) begin
          err_q   <= ERR_RANGE;
          state_q <= S_ERR;
        end else begin
          blk_cur_q   <= addr_q[FLASH_ADDR_WD-1:BLK_SHIFT];
          blk_last_q  <= end_w[FLASH_ADDR_WD-1:BLK_SHIFT];
          block_num_q <= {addr_q[FLASH_ADDR_WD-1:BLK_SHIFT], {BLK_SHIFT{1'b0}}};
          state_q     <= S_ERASE;
        end
        S_ERASE: state_q <= S_POLL;
        S_POLL: if (poll_tmo) begin
          err_q   <= ERR_TMO;
          state_q <= S_ERR;
        end else if (poll_done) begin
          err_q   <= sts_q[SR_LOCK] ? ERR_LOCK : ERR_ERASE;
          state_q <= S_ERR;
          if (!sts_q[SR_LOCK] && !sts_q[SR_ERASE_ERR]) begin
            err_q     <= ERR_OK;
            blk_cnt_q <= blk_cnt_q + 16'd1;
            state_q   <= blk_cur_q == blk_last_q ? S_WR : S_ERASE;
            if (blk_cur_q != blk_last_q) begin
              blk_cur_q   <= blk_cur_q + BW'(1);
              block_num_q <= {blk_cur_q + BW'(1), {BLK_SHIFT{1'b0}}};
            end
          end
        end
        S_WR: begin
          wcnt_q  <= '0;
          state_q <= S_WR_WAIT;
        end
        S_WR_WAIT: if (wcnt_q != 2'd2) wcnt_q <= wcnt_q + 2'd1;
        else if (sts_wr_cpl) state_q <= S_WCHK;
        S_WCHK: if (poll_tmo) begin
          err_q   <= ERR_TMO;
          state_q <= S_ERR;
        end else if (poll_done) begin
          err_q   <= sts_q[SR_PROG_ERR] ? ERR_PROG : ERR_OK;
          state_q <= sts_q[SR_PROG_ERR] ? S_ERR : S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
